// File: rtl/arb_types.sv
// Shared types for the memory port arbiter: FSM state and grant encodings.
package arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  // Returns the side opposite to the one given.
  function automatic arb_grant_t other_side(input arb_grant_t g);
    arb_grant_t r;
    case (g)
      GRANT_I: r = GRANT_D;
      GRANT_D: r = GRANT_I;
      default: r = GRANT_D;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational grant selection. When both sides request, the side opposite
// to last_grant wins; tying last_grant to GRANT_I gives fixed data priority.
module arb_select
  import arb_types::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_grant_t last_grant,
  output arb_grant_t grant
);

  // Pick the winning side for this IDLE cycle.
  always_comb begin
    grant = GRANT_I;
    if (i_req && d_req) begin
      grant = other_side(last_grant);
    end else if (d_req) begin
      grant = GRANT_D;
    end else begin
      grant = GRANT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction port and a data port onto one shared memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants when both sides request;
// without it the data side always wins a tie.
module mem_port_arbiter
  import arb_types::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [DATA_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wmask,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;

  logic              i_req_s;
  logic              d_req_s;
  arb_grant_t        last_grant_s;
  arb_grant_t        sel_grant_s;

  assign i_req_s = i_read;
  assign d_req_s = d_read | d_write;

  arb_select u_arb_select (
    .i_req      (i_req_s),
    .d_req      (d_req_s),
    .last_grant (last_grant_s),
    .grant      (sel_grant_s)
  );

`ifdef ARB_ROUND_ROBIN_EN
  arb_grant_t last_grant_q, last_grant_d;

  // Remember which side won the most recent arbitration.
  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == IDLE) && (i_req_s || d_req_s)) begin
      last_grant_d = sel_grant_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant flag register; resets to the instruction side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_s = last_grant_q;
`else
  // Constant GRANT_I makes a tie always resolve to the data side.
  assign last_grant_s = GRANT_I;
`endif

  // Next-state and datapath next values for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_resp_d    = 1'b0;
    d_resp_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_s || d_req_s) begin
          if (sel_grant_s == GRANT_D) begin
            state_d     = SERVE_D;
            addr_d      = d_addr;
            wdata_d     = d_wdata;
            wmask_d     = d_wmask;
            mem_write_d = d_write;
            mem_read_d  = d_read & ~d_write;
          end else begin
            state_d     = SERVE_I;
            addr_d      = i_addr;
            wdata_d     = {DATA_W{1'b0}};
            wmask_d     = 4'h0;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          state_d     = RESPOND;
          i_rdata_d   = mem_rdata;
          i_resp_d    = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else begin
          state_d = SERVE_I;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          state_d     = RESPOND;
          d_resp_d    = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else begin
          state_d = SERVE_D;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State, request latches and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= {DATA_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      wmask_q     <= 4'h0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_rdata_q   <= {DATA_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_resp_q    <= i_resp_d;
      d_resp_q    <= d_resp_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;

endmodule
